cga_vram_sequencer: RTL and testbench
=====================================

Name: cga_vram_sequencer

Overview:
- Drives the VRAM fetch schedule consumed by the CGA/Tandy pixel path.
- Runs the per-character clock sequencer and produces the `clk_seq` count plus the fetch strobes: `vram_read_char`, `vram_read_att`, `charrom_read` and `disp_pipeline`.
- Forms text and graphics VRAM addresses from the CRTC memory address and row address.
- Arbitrates CPU accesses into free slots, so display fetches are never disturbed (no snow).
- Sits between the CRTC, the VRAM macro, the bus interface and the pixel block.

Parameters:
- VRAM_AW, 14, VRAM byte address width (16 KB).
- CPU_FIRST_SLOT, 4, first `clk_seq` value at which a CPU access may be accepted.

Ports:
- clk  in  1  video clock (28.636 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- hres_mode  in  1  1: 16-clk character period; 0: 32-clk period
- grph_mode  in  1  graphics addressing when 1
- crtc_ma  in  13  CRTC memory address for current character
- row_addr  in  5  CRTC row address
- vram_rdata  in  8  VRAM read data, valid one clk after address
- vram_addr  out  14  VRAM byte address
- vram_we  out  1  VRAM write strobe
- vram_wdata  out  8  VRAM write data
- vram_data  out  8  registered copy of vram_rdata to pixel block
- vram_read_char  out  1  char/graphics byte 0 valid on vram_data
- vram_read_att  out  1  attr/graphics byte 1 valid on vram_data
- charrom_read  out  1  char ROM lookup strobe
- disp_pipeline  out  1  attribute/cursor pipeline advance
- hclk  out  1  one-clk CRTC character clock enable
- clk_seq  out  5  character-period sequence count
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  write when 1
- cpu_addr  in  14  CPU VRAM byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-clk completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack

Behaviour:
- **Reset (async assert, sync release):**
  - `clk_seq`, all strobes, `vram_we`, `cpu_ack` = 0.
  - `vram_addr`, `vram_data`, `cpu_rdata`, `vram_wdata` = 0.
  - Arbiter state = IDLE.
- **Period:** N = 16 if `hres_mode`, else 32.
  - `clk_seq` increments each clk and wraps from N-1 to 0.
  - If `hres_mode` rises while `clk_seq` > 15, `clk_seq` goes to 0 on the next clk.
- **Display address:**
  - Text: `{crtc_ma[12:0], b}`.
  - Graphics: `{row_addr[0], crtc_ma[11:0], b}`.
  - b = 0 for the char/byte0 fetch, b = 1 for the attr/byte1 fetch.
- **Fixed display slots (P = clk_seq):**
  - P=0: `vram_addr` = address with b=0.
  - P=1: `vram_addr` = address with b=1; `vram_data` <= `vram_rdata`. Strobes and data are registered, so the pixel block sees `vram_read_char`=1 together with byte0 during P=2.
  - P=2: `vram_data` <= byte1; `vram_read_att`=1 during P=3.
  - `charrom_read` = 1 during P=4.
  - `disp_pipeline` and `hclk` = 1 during P=N-1.
  - Every strobe is exactly one clk wide, once per period.
- **CPU arbiter FSM: IDLE -> ACCESS -> DONE -> IDLE.**
  - IDLE -> ACCESS when `cpu_req`=1 and CPU_FIRST_SLOT ≤ P ≤ N-4.
  - In ACCESS (1 clk): `vram_addr`=`cpu_addr`, `vram_we`=`cpu_we`, `vram_wdata`=`cpu_wdata`.
  - DONE (1 clk): `cpu_rdata` <= `vram_rdata` (reads only; unchanged on writes); `cpu_ack`=1.
  - DONE -> IDLE always.
  - A request outside the window waits; there is no timeout.
  - A request that completes while `cpu_req` remains high re-enters ACCESS on the next eligible slot as a new access.
  - The window bound guarantees ACCESS and DONE finish before P=0, so display slots always win. CPU never drives `vram_addr` during P ∈ {0,1}.
- **Mode change:** if `hres_mode` falls mid-ACCESS, the access still completes normally.
- **Reset mid-access:** the access is abandoned, no `cpu_ack` is issued, and `vram_we` drops immediately.
- Outside P=0/1 and ACCESS, `vram_addr` holds its last value and `vram_we`=0.

Test Plan:
- **Hi-res sequencing:** reset release, `hres_mode`=1, `crtc_ma`=13'h0123, text mode. Expected: `vram_addr`=14'h0246 at P=0 and 14'h0247 at P=1. Char strobe during P=2, att during P=3, `charrom_read` during P=4. `hclk` and `disp_pipeline` during P=15. Period is 16.
- **Lo-res graphics:** `hres_mode`=0, `grph_mode`=1, `row_addr`=1, `crtc_ma`=0x010. Expected: `vram_addr`=14'h2020 then 14'h2021. `hclk` fires every 32 clks, at P=31.
- **CPU write:** `cpu_req` with `cpu_we`=1, addr 0x1000, data 0xA5, asserted at P=1 (hres). Expected: waits to P=4; `vram_we`=1 with addr 0x1000 at P=4; `cpu_ack` at P=5; VRAM holds 0xA5.
- **CPU read near boundary:** request at P=13 (hres, last legal slot 12) with VRAM[0x0005]=0x3C. Expected: access deferred to next period P=4; `cpu_rdata`=0x3C with `cpu_ack`; display strobes undisturbed.
- **Mode switch:** set `hres_mode`=1 while `clk_seq`=20. Expected: `clk_seq`=0 next clk; no strobe duplicated or lost beyond that boundary.
- **Reset during ACCESS:** drop `reset_n` during a CPU write. Expected: `vram_we`=0 immediately, no `cpu_ack`, FSM=IDLE, `clk_seq`=0.

Source files
------------

// File: rtl/cga_vram_sequencer_if.sv
// -----------------------------------------------------------------------------
// cga_vram_sequencer_if
//   Bundles the CRTC inputs, VRAM macro port, pixel-block strobes and the CPU
//   access port of the VRAM sequencer.
//
//   Modports:
//     master : the sequencer (drives VRAM address/write, strobes, cpu_ack).
//     slave  : the surroundings (CRTC, VRAM macro, bus interface, pixel block).
//
//   CPU handshake: cpu_req acts as "valid" and is held, with cpu_we/cpu_addr/
//   cpu_wdata stable, until the sequencer returns a one-clk cpu_ack ("done").
//   cpu_rdata is valid in the cpu_ack cycle. If cpu_req is still high after
//   cpu_ack, that is taken as a new request.
//
//   arb_state exposes the arbiter FSM state (0 IDLE, 1 ACCESS, 2 DONE).
// -----------------------------------------------------------------------------
interface cga_vram_sequencer_if #(
    parameter int VRAM_AW = 14
);
    // CRTC / mode inputs
    logic               hres_mode;
    logic               grph_mode;
    logic [12:0]        crtc_ma;
    logic [4:0]         row_addr;
    // VRAM macro
    logic [7:0]         vram_rdata;
    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_we;
    logic [7:0]         vram_wdata;
    // Pixel block
    logic [7:0]         vram_data;
    logic               vram_read_char;
    logic               vram_read_att;
    logic               charrom_read;
    logic               disp_pipeline;
    logic               hclk;
    logic [4:0]         clk_seq;
    // CPU port
    logic               cpu_req;
    logic               cpu_we;
    logic [VRAM_AW-1:0] cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               cpu_ack;
    logic [7:0]         cpu_rdata;
    // Debug
    logic [1:0]         arb_state;

    modport master (
        input  hres_mode, grph_mode, crtc_ma, row_addr, vram_rdata,
               cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vram_addr, vram_we, vram_wdata, vram_data,
               vram_read_char, vram_read_att, charrom_read, disp_pipeline,
               hclk, clk_seq, cpu_ack, cpu_rdata, arb_state
    );

    modport slave (
        output hres_mode, grph_mode, crtc_ma, row_addr, vram_rdata,
               cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vram_addr, vram_we, vram_wdata, vram_data,
               vram_read_char, vram_read_att, charrom_read, disp_pipeline,
               hclk, clk_seq, cpu_ack, cpu_rdata, arb_state
    );
endinterface

// File: rtl/cga_vram_sequencer.sv
// -----------------------------------------------------------------------------
// cga_vram_sequencer
//   Per-character VRAM fetch scheduler for the CGA/Tandy pixel path.
//   A 16- or 32-clk character period (clk_seq) fixes two display fetch slots
//   (P=0 byte0/char, P=1 byte1/attr); CPU accesses are slotted into the free
//   window CPU_FIRST_SLOT..N-4 so they never collide with display fetches.
//
//   Ports:
//     clk      : video clock
//     reset_n  : asynchronous active-low reset
//     bus      : cga_vram_sequencer_if.master (CRTC, VRAM, pixel, CPU, debug)
//
//   Timing: vram_addr and all strobes are registers loaded from the *next*
//   clk_seq value, so each appears in the cycle where clk_seq equals its slot.
//   VRAM data returns one clk after the address.
// -----------------------------------------------------------------------------
module cga_vram_sequencer #(
    parameter int VRAM_AW        = 14,
    parameter int CPU_FIRST_SLOT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cga_vram_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    arb_state_t         r_state;
    arb_state_t         w_state_next;

    logic [4:0]         r_clk_seq;
    logic [4:0]         w_seq_next;
    logic [4:0]         w_last_slot;
    logic               w_cpu_slot;
    logic               w_start;
    logic [13:0]        w_disp_addr0;
    logic [13:0]        w_disp_addr1;

    logic [VRAM_AW-1:0] r_vram_addr;
    logic [7:0]         r_vram_wdata;
    logic               r_cpu_we;
    logic [7:0]         r_vram_data;
    logic [7:0]         r_cpu_rdata;
    logic               r_read_char;
    logic               r_read_att;
    logic               r_charrom_read;
    logic               r_disp_pipeline;
    logic               r_hclk;

    // ------------------------------------------------------------------
    // Character-period sequencer
    // ------------------------------------------------------------------
    assign w_last_slot = bus.hres_mode ? 5'd15 : 5'd31;

    // Switching into hi-res from a lo-res position past 15 restarts the
    // period at 0 instead of running on to 31. The 32-clk wrap is the
    // natural 5-bit overflow.
    always_comb begin
        if (bus.hres_mode && (r_clk_seq >= 5'd15)) begin
            w_seq_next = 5'd0;
        end else begin
            w_seq_next = r_clk_seq + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_seq <= 5'd0;
        end else begin
            r_clk_seq <= w_seq_next;
        end
    end

    // ------------------------------------------------------------------
    // Display address
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.grph_mode) begin
            w_disp_addr0 = {bus.row_addr[0], bus.crtc_ma[11:0], 1'b0};
        end else begin
            w_disp_addr0 = {bus.crtc_ma, 1'b0};
        end
        w_disp_addr1 = w_disp_addr0 | 14'd1;
    end

    // ------------------------------------------------------------------
    // CPU arbiter FSM
    // ------------------------------------------------------------------
    // The slot check uses the next clk_seq because ACCESS is the cycle after
    // the decision. Capping at N-4 keeps ACCESS and DONE clear of P=0.
    assign w_cpu_slot = (w_seq_next >= 5'(CPU_FIRST_SLOT)) &&
                        (w_seq_next <= (w_last_slot - 5'd3));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (bus.cpu_req && w_cpu_slot) begin
                    w_state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: w_state_next = ARB_DONE;
            ARB_DONE:   w_state_next = ARB_IDLE;
            default:    w_state_next = ARB_IDLE;
        endcase
    end

    assign w_start = (r_state == ARB_IDLE) && (w_state_next == ARB_ACCESS);

    // Read data arrives during DONE; it is passed straight through so it is
    // valid alongside cpu_ack, and captured so it holds afterwards.
    always_comb begin
        bus.vram_we   = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = r_cpu_rdata;
        case (r_state)
            ARB_ACCESS: bus.vram_we = r_cpu_we;
            ARB_DONE: begin
                bus.cpu_ack = 1'b1;
                if (!r_cpu_we) begin
                    bus.cpu_rdata = bus.vram_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.arb_state = r_state;

    // ------------------------------------------------------------------
    // Address / data path and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_addr     <= '0;
            r_vram_wdata    <= 8'd0;
            r_cpu_we        <= 1'b0;
            r_vram_data     <= 8'd0;
            r_cpu_rdata     <= 8'd0;
            r_read_char     <= 1'b0;
            r_read_att      <= 1'b0;
            r_charrom_read  <= 1'b0;
            r_disp_pipeline <= 1'b0;
            r_hclk          <= 1'b0;
        end else begin
            // Display slots take priority; a CPU start can never coincide
            // with them because of the slot window.
            if (w_seq_next == 5'd0) begin
                r_vram_addr <= VRAM_AW'(w_disp_addr0);
            end else if (w_seq_next == 5'd1) begin
                r_vram_addr <= VRAM_AW'(w_disp_addr1);
            end else if (w_start) begin
                r_vram_addr <= bus.cpu_addr;
            end

            if (w_start) begin
                r_vram_wdata <= bus.cpu_wdata;
                r_cpu_we     <= bus.cpu_we;
            end

            // Byte0 returns during P=1, byte1 during P=2.
            if ((r_clk_seq == 5'd1) || (r_clk_seq == 5'd2)) begin
                r_vram_data <= bus.vram_rdata;
            end

            if ((r_state == ARB_DONE) && !r_cpu_we) begin
                r_cpu_rdata <= bus.vram_rdata;
            end

            r_read_char     <= (w_seq_next == 5'd2);
            r_read_att      <= (w_seq_next == 5'd3);
            r_charrom_read  <= (w_seq_next == 5'd4);
            r_disp_pipeline <= (w_seq_next == w_last_slot);
            r_hclk          <= (w_seq_next == w_last_slot);
        end
    end

    assign bus.clk_seq        = r_clk_seq;
    assign bus.vram_addr      = r_vram_addr;
    assign bus.vram_wdata     = r_vram_wdata;
    assign bus.vram_data      = r_vram_data;
    assign bus.vram_read_char = r_read_char;
    assign bus.vram_read_att  = r_read_att;
    assign bus.charrom_read   = r_charrom_read;
    assign bus.disp_pipeline  = r_disp_pipeline;
    assign bus.hclk           = r_hclk;

endmodule

// File: tb/tb_cga_vram_sequencer.sv
module tb_cga_vram_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cga_vram_sequencer_if bus_if ();

  cga_vram_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_map[int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] init_byte(input int a);
    logic [13:0] aa;
    aa = a[13:0];
    return aa[7:0] ^ {2'b00, aa[13:8]} ^ 8'h39;
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    if (wr_map.exists(a)) return wr_map[a];
    return init_byte(a);
  endfunction

  function automatic int period(input bit h);
    return h ? 16 : 32;
  endfunction

  function automatic bit in_window(input int p, input int n);
    return (p >= 4) && (p <= n - 4);
  endfunction

  function automatic logic [4:0] exp_strobes(input int p, input int n);
    return {p == 2, p == 3, p == 4, p == n - 1, p == n - 1};
  endfunction

  function automatic logic [13:0] disp_addr(input bit g, input logic [12:0] ma,
                                            input logic [4:0] row, input bit b);
    if (g) return {row[0], ma[11:0], b};
    return {ma, b};
  endfunction

  // Cycles from raising a request until cpu_ack: the first period position
  // at or after offset k0 inside the CPU window is ACCESS, ack follows it.
  function automatic int exp_latency(input int p0, input int n, input int k0);
    int k;
    k = k0;
    while (!in_window((p0 + k) % n, n)) k++;
    return k + 1;
  endfunction

  function automatic logic [4:0] got_strobes();
    return {bus_if.vram_read_char, bus_if.vram_read_att, bus_if.charrom_read,
            bus_if.disp_pipeline, bus_if.hclk};
  endfunction

  // ---------------- VRAM model (1-clk read latency) ----------------
  logic [7:0] vmem [0:16383];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 16384; a++) vmem[a] <= init_byte(a);
      mem_ready <= 1'b1;
    end else begin
      bus_if.vram_rdata <= vmem[bus_if.vram_addr];
      if (bus_if.vram_we) vmem[bus_if.vram_addr] <= bus_if.vram_wdata;
    end
  end

  // ---------------- background display monitor ----------------
  bit mon_en = 1'b0;
  int mon_cnt = 0;
  int mon_prev = 0;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      int n;
      int p;
      logic [13:0] a0;
      n  = period(bus_if.hres_mode);
      p  = int'(bus_if.clk_seq);
      a0 = disp_addr(bus_if.grph_mode, bus_if.crtc_ma, bus_if.row_addr, 1'b0);
      if (mon_cnt > 0) check("mon_seq_step", p, (mon_prev + 1) % n);
      check("mon_strobes", got_strobes(), exp_strobes(p, n));
      if (bus_if.vram_we) check("mon_we_window", in_window(p, n), 1);
      if (mon_cnt >= n) begin
        if (p == 0) check("mon_addr0", bus_if.vram_addr, a0);
        if (p == 1) check("mon_addr1", bus_if.vram_addr, a0 | 14'd1);
        if (p == 2) check("mon_data0", bus_if.vram_data, model_byte(a0));
        if (p == 3) check("mon_data1", bus_if.vram_data, model_byte(a0 | 14'd1));
      end
      mon_prev = p;
      mon_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit h, input bit g, input logic [12:0] ma, input logic [4:0] row);
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_we    = 1'b0;
    bus_if.hres_mode = h;
    bus_if.grph_mode = g;
    bus_if.crtc_ma   = ma;
    bus_if.row_addr  = row;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_cnt = 0;
  endtask

  task automatic wait_seq(input logic [4:0] p);
    int k;
    k = 0;
    while (bus_if.clk_seq !== p && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_seq", bus_if.clk_seq, p);
  endtask

  task automatic drive_req(input bit we, input logic [13:0] addr, input logic [7:0] data);
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = we;
    bus_if.cpu_addr  = addr;
    bus_if.cpu_wdata = data;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          hres;
    bit          grph;
    logic [12:0] ma;
    logic [4:0]  row;
    logic [13:0] a0;
    logic [13:0] a1;
    int          n;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int gap, p0, k0, lat, elat, n;
    bit got, we;
    logic [13:0] addr;
    logic [7:0] data, eb;
    int hclk_cnt;

    vecs[0] = '{1'b1, 1'b0, 13'h0123, 5'd0, 14'h0246, 14'h0247, 16};
    vecs[1] = '{1'b0, 1'b1, 13'h0010, 5'd1, 14'h2020, 14'h2021, 32};
    vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 5'd0, 14'h1FFE, 14'h1FFF, 16};
    vecs[3] = '{1'b0, 1'b0, 13'h1ABC, 5'd3, 14'h3578, 14'h3579, 32};
    vecs[4] = '{1'b1, 1'b1, 13'h0FFF, 5'd1, 14'h3FFE, 14'h3FFF, 16};

    bus_if.hres_mode = 1'b1;
    bus_if.grph_mode = 1'b0;
    bus_if.crtc_ma   = 13'h0;
    bus_if.row_addr  = 5'h0;
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_we    = 1'b0;
    bus_if.cpu_addr  = 14'h0;
    bus_if.cpu_wdata = 8'h0;

    // Reset state
    #2;
    check("rst_clk_seq", bus_if.clk_seq, 0);
    check("rst_strobes", got_strobes(), 0);
    check("rst_vram_we", bus_if.vram_we, 0);
    check("rst_cpu_ack", bus_if.cpu_ack, 0);
    check("rst_vram_addr", bus_if.vram_addr, 0);
    check("rst_vram_data", bus_if.vram_data, 0);
    check("rst_cpu_rdata", bus_if.cpu_rdata, 0);
    check("rst_vram_wdata", bus_if.vram_wdata, 0);
    check("rst_arb_state", bus_if.arb_state, 0);

    // Table-driven display sequencing
    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].hres, vecs[v].grph, vecs[v].ma, vecs[v].row);
      hclk_cnt = 0;
      for (int c = 0; c < 3 * vecs[v].n; c++) begin
        int p;
        p = c % vecs[v].n;
        check("tbl_seq", bus_if.clk_seq, p);
        check("tbl_strobes", got_strobes(), exp_strobes(p, vecs[v].n));
        check("tbl_we", bus_if.vram_we, 0);
        if (p == 1) check("tbl_addr1", bus_if.vram_addr, vecs[v].a1);
        if (p == 0 && c >= vecs[v].n) check("tbl_addr0", bus_if.vram_addr, vecs[v].a0);
        if (p == 2 && c >= vecs[v].n) check("tbl_data0", bus_if.vram_data, init_byte(vecs[v].a0));
        if (p == 3 && c >= vecs[v].n) check("tbl_data1", bus_if.vram_data, init_byte(vecs[v].a1));
        hclk_cnt += int'(bus_if.hclk);
        @(negedge clk);
      end
      check("tbl_hclk_count", hclk_cnt, 3);
    end

    // CPU write requested at P=1, hi-res
    do_reset(1'b1, 1'b0, 13'h0123, 5'd0);
    mon_en = 1'b1;
    wait_seq(5'd1);
    drive_req(1'b1, 14'h1000, 8'hA5);
    @(negedge clk); check("wr_p2_we", bus_if.vram_we, 0);
    @(negedge clk); check("wr_p3_we", bus_if.vram_we, 0);
    check("wr_p3_ack", bus_if.cpu_ack, 0);
    @(negedge clk);
    check("wr_p4_seq", bus_if.clk_seq, 4);
    check("wr_p4_state", bus_if.arb_state, 1);
    check("wr_p4_we", bus_if.vram_we, 1);
    check("wr_p4_addr", bus_if.vram_addr, 14'h1000);
    check("wr_p4_wdata", bus_if.vram_wdata, 8'hA5);
    @(negedge clk);
    check("wr_p5_ack", bus_if.cpu_ack, 1);
    check("wr_p5_we", bus_if.vram_we, 0);
    bus_if.cpu_req = 1'b0;
    wr_map[14'h1000] = 8'hA5;
    @(negedge clk);
    check("wr_p6_ack", bus_if.cpu_ack, 0);
    check("wr_mem", vmem[14'h1000], 8'hA5);
    check("wr_p6_state", bus_if.arb_state, 0);

    // CPU read requested at P=13: deferred to the next period
    wait_seq(5'd13);
    drive_req(1'b0, 14'h0005, 8'h00);
    lat = 0; got = 1'b0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      lat++;
      if (bus_if.cpu_ack) got = 1'b1;
    end
    check("rd_latency", lat, 8);
    check("rd_ack_seq", bus_if.clk_seq, 5);
    check("rd_rdata", bus_if.cpu_rdata, 8'h3C);
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    check("rd_rdata_hold", bus_if.cpu_rdata, 8'h3C);
    repeat (20) @(negedge clk);

    // Mode switch: lo-res at P=20, hres_mode rises
    do_reset(1'b0, 1'b0, 13'h0123, 5'd0);
    wait_seq(5'd20);
    bus_if.hres_mode = 1'b1;
    @(negedge clk);
    check("ms_seq0", bus_if.clk_seq, 0);
    check("ms_addr0", bus_if.vram_addr, 14'h0246);
    hclk_cnt = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      check("ms_seq", bus_if.clk_seq, k);
      check("ms_strobes", got_strobes(), exp_strobes(k, 16));
      if (k == 2) check("ms_data0", bus_if.vram_data, init_byte(14'h0246));
      hclk_cnt += int'(bus_if.hclk);
    end
    check("ms_hclk_count", hclk_cnt, 1);

    // hres_mode falls during ACCESS: access still completes
    do_reset(1'b1, 1'b0, 13'h0123, 5'd0);
    wait_seq(5'd11);
    drive_req(1'b0, 14'h0100, 8'h00);
    @(negedge clk);
    check("mf_access", bus_if.arb_state, 1);
    bus_if.hres_mode = 1'b0;
    @(negedge clk);
    check("mf_ack", bus_if.cpu_ack, 1);
    check("mf_rdata", bus_if.cpu_rdata, model_byte(14'h0100));
    bus_if.cpu_req = 1'b0;
    @(negedge clk);

    // Reset during a write ACCESS
    do_reset(1'b1, 1'b0, 13'h0123, 5'd0);
    wait_seq(5'd3);
    drive_req(1'b1, 14'h0200, 8'h77);
    @(negedge clk);
    check("ra_we_before", bus_if.vram_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("ra_we", bus_if.vram_we, 0);
    check("ra_ack", bus_if.cpu_ack, 0);
    check("ra_state", bus_if.arb_state, 0);
    check("ra_seq", bus_if.clk_seq, 0);
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    check("ra_ack_later", bus_if.cpu_ack, 0);
    check("ra_mem_untouched", vmem[14'h0200], init_byte(14'h0200));
    reset_n = 1'b1;

    // Randomized CPU traffic against the latency/memory model
    for (int m = 0; m < 2; m++) begin
      do_reset(m == 0, 1'b0, 13'h0400, 5'd0);
      mon_en = 1'b1;
      n = period(m == 0);
      gap = $urandom_range(1, 6);
      for (int t = 0; t < 25; t++) begin
        if (gap > 0) begin
          bus_if.cpu_req = 1'b0;
          repeat (gap) @(negedge clk);
        end
        p0 = int'(bus_if.clk_seq);
        k0 = (gap == 0) ? 2 : 1;
        elat = exp_latency(p0, n, k0);
        we   = 1'($urandom_range(0, 1));
        addr = 14'h0100 + 14'($urandom_range(0, 63));
        data = 8'($urandom_range(0, 255));
        if (we) wr_map[int'(addr)] = data;
        else exp_q.push_back(model_byte(int'(addr)));
        drive_req(we, addr, data);
        lat = 0; got = 1'b0;
        while (lat < 80 && !got) begin
          @(negedge clk);
          lat++;
          if (bus_if.cpu_ack) got = 1'b1;
        end
        check("rnd_latency", lat, elat);
        if (!we) begin
          eb = exp_q.pop_front();
          if (got) check("rnd_rdata", bus_if.cpu_rdata, eb);
        end else begin
          check("rnd_wmem", vmem[int'(addr)], data);
        end
        gap = $urandom_range(0, 4);
      end
      bus_if.cpu_req = 1'b0;
      repeat (n) @(negedge clk);
    end
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
